// File: rtl/coef_entry_ctrl.sv
// coef_entry_ctrl: keypad-driven BCD coefficient editor with sequential BCD<->binary SAVE/LOAD engines.
// Define COEF_ENTRY_WRAP_EN to make left/right navigation wrap around at the ends of the coefficient list.
module coef_entry_ctrl #(
   parameter int NUM_COEFS  = 5,
   parameter int NUM_DIGITS = 5,
   parameter int COEF_W     = 32,
   parameter int PAN_W      = 12,
   parameter int PAN_INIT   = 400,
   parameter int PAN_STEP   = 10
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_key_dig_v,
   input  logic [3:0]                    i_key_dig,
   input  logic                          i_key_del,
   input  logic                          i_key_sign,
   input  logic                          i_key_left,
   input  logic                          i_key_right,
   input  logic                          i_key_mode,
   output logic [4*NUM_DIGITS-1:0]       o_digits,
   output logic                          o_sign_neg,
   output logic [$clog2(NUM_COEFS)-1:0]  o_cur_idx,
   output logic [COEF_W*NUM_COEFS-1:0]   o_coefs,
   output logic                          o_graph_mode,
   output logic [PAN_W-1:0]              o_pan_x,
   output logic                          o_busy
);
   localparam int IW = $clog2(NUM_COEFS);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_COEFS - 1);
   localparam logic [COEF_W-1:0] TEN = COEF_W'(10);

   typedef enum logic [1:0] {S_EDIT, S_SAVE, S_LOAD} state_t;

   state_t                    r_state;
   logic [DW-1:0]             r_digits;
   logic                      r_sign;
   logic [IW-1:0]             r_idx;
   logic [IW-1:0]             r_tgt;
   logic                      r_tog;
   logic signed [COEF_W-1:0]  r_coefs [NUM_COEFS];
   logic                      r_graph;
   logic [PAN_W-1:0]          r_pan;
   logic [COEF_W-1:0]         r_acc;
   logic [CW-1:0]             r_cnt;

   logic [3:0]                w_sdig;
   logic [3:0]                w_mdig;
   logic [COEF_W-1:0]         w_acc_nx;
   logic                      w_last;
   logic signed [COEF_W-1:0]  w_ld_coef;
   logic                      w_ld_neg;
   logic [COEF_W-1:0]         w_ld_mag;
   logic                      w_can_l;
   logic                      w_can_r;
   logic [IW-1:0]             w_tgt_l;
   logic [IW-1:0]             w_tgt_r;

   // SAVE walks digits MSD first; r_acc doubles as the LOAD magnitude register
   assign w_sdig    = r_digits[4*(NUM_DIGITS-1-int'(r_cnt)) +: 4];
   assign w_acc_nx  = r_acc * TEN + COEF_W'(w_sdig);
   assign w_mdig    = 4'(r_acc % TEN);
   assign w_last    = r_cnt == CW'(NUM_DIGITS - 1);
   assign w_ld_coef = r_coefs[r_tgt];
   assign w_ld_neg  = w_ld_coef[COEF_W-1];
   assign w_ld_mag  = w_ld_neg ? COEF_W'(-w_ld_coef) : COEF_W'(w_ld_coef);

`ifdef COEF_ENTRY_WRAP_EN
   assign w_can_l = 1'b1;
   assign w_can_r = 1'b1;
   assign w_tgt_l = (r_idx == '0) ? LAST : r_idx - IW'(1);
   assign w_tgt_r = (r_idx == LAST) ? '0 : r_idx + IW'(1);
`else
   assign w_can_l = r_idx != '0;
   assign w_can_r = r_idx != LAST;
   assign w_tgt_l = r_idx - IW'(1);
   assign w_tgt_r = r_idx + IW'(1);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_EDIT;
         r_digits <= '0;
         r_sign   <= 1'b0;
         r_idx    <= '0;
         r_tgt    <= '0;
         r_tog    <= 1'b0;
         r_graph  <= 1'b0;
         r_pan    <= PAN_W'(PAN_INIT);
         r_acc    <= '0;
         r_cnt    <= '0;
         for (int k = 0; k < NUM_COEFS; k++) r_coefs[k] <= '0;
      end else begin
         case (r_state)
            S_EDIT: begin
               r_acc <= '0;
               r_cnt <= '0;
               if (i_key_mode) begin
                  if (r_graph) r_graph <= 1'b0;
                  else begin
                     r_tog   <= 1'b1;
                     r_state <= S_SAVE;
                  end
               end else if (i_key_left) begin
                  if (r_graph) r_pan <= r_pan + PAN_W'(PAN_STEP);
                  else if (w_can_l) begin
                     r_tog   <= 1'b0;
                     r_tgt   <= w_tgt_l;
                     r_state <= S_SAVE;
                  end
               end else if (i_key_right) begin
                  if (r_graph) r_pan <= r_pan - PAN_W'(PAN_STEP);
                  else if (w_can_r) begin
                     r_tog   <= 1'b0;
                     r_tgt   <= w_tgt_r;
                     r_state <= S_SAVE;
                  end
               end else if (!r_graph) begin
                  if (i_key_sign) r_sign <= ~r_sign;
                  else if (i_key_del) r_digits <= r_digits >> 4;
                  else if (i_key_dig_v && i_key_dig <= 4'd9 && r_digits[DW-1 -: 4] == 4'd0)
                     r_digits <= (r_digits << 4) | DW'(i_key_dig);
               end
            end
            S_SAVE: begin
               r_acc <= w_acc_nx;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_coefs[r_idx] <= r_sign ? -w_acc_nx : w_acc_nx;
                  r_cnt          <= '0;
                  if (r_tog) begin
                     r_graph <= 1'b1;
                     r_state <= S_EDIT;
                  end else begin
                     r_idx   <= r_tgt;
                     r_acc   <= w_ld_mag;
                     r_sign  <= w_ld_neg;
                     r_state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               // shift in from the top so the first remainder lands at digit 0 after NUM_DIGITS steps
               r_digits <= (r_digits >> 4) | (DW'(w_mdig) << (DW - 4));
               r_acc    <= r_acc / TEN;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) r_state <= S_EDIT;
            end
            default: r_state <= S_EDIT;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_COEFS; k++) begin : g_out
      assign o_coefs[k*COEF_W +: COEF_W] = r_coefs[k];
   end

   assign o_digits     = r_digits;
   assign o_sign_neg   = r_sign;
   assign o_cur_idx    = r_idx;
   assign o_graph_mode = r_graph;
   assign o_pan_x      = r_pan;
   assign o_busy       = r_state != S_EDIT;
endmodule

// File: tb/tb_coef_entry_ctrl.sv
// tb_coef_entry_ctrl: randomized key sequences against a value-level model; a monitor pops expected
// snapshots from a queue whenever the editor is idle again and also checks the busy duration.
module tb_coef_entry_ctrl;
   localparam int NC = 5, ND = 5, CW = 32, PW = 12, PINIT = 400, PSTEP = 10, LIM = 10000;
`ifdef COEF_ENTRY_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic key_dig_v = 0, key_del = 0, key_sign = 0, key_left = 0, key_right = 0, key_mode = 0;
   logic [3:0] key_dig = '0;
   logic [4*ND-1:0] digits;
   logic sign_neg, graph_mode, busy;
   logic [2:0] cur_idx;
   logic [CW*NC-1:0] coefs;
   logic [PW-1:0] pan_x;

   always #5 clk = ~clk;

   coef_entry_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_dig_v(key_dig_v), .i_key_dig(key_dig),
      .i_key_del(key_del), .i_key_sign(key_sign), .i_key_left(key_left), .i_key_right(key_right),
      .i_key_mode(key_mode), .o_digits(digits), .o_sign_neg(sign_neg), .o_cur_idx(cur_idx),
      .o_coefs(coefs), .o_graph_mode(graph_mode), .o_pan_x(pan_x), .o_busy(busy)
   );

   typedef struct packed {
      logic [31:0]      val;
      logic             neg;
      logic [2:0]       idx;
      logic             gr;
      logic [11:0]      pan;
      logic [CW*NC-1:0] c;
      logic [7:0]       lat;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int total = 0, bad = 0, bcnt = 0;
   int m_val, m_idx, m_pan, m_c[NC];
   bit m_neg, m_gr;

   task automatic chk(input string n, input longint act, input longint ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, ex, $time);
      end
   endtask

   function automatic logic [4*ND-1:0] bcd(input int v);
      logic [4*ND-1:0] r;
      for (int k = 0; k < ND; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic exp_t snap(input int lat);
      exp_t x;
      x.val = m_val; x.neg = m_neg; x.idx = 3'(m_idx); x.gr = m_gr; x.pan = 12'(m_pan);
      for (int k = 0; k < NC; k++) x.c[CW*k +: CW] = CW'(m_c[k]);
      x.lat = 8'(lat);
      return x;
   endfunction

   task automatic m_reset;
      m_val = 0; m_neg = 0; m_idx = 0; m_gr = 0; m_pan = PINIT;
      for (int k = 0; k < NC; k++) m_c[k] = 0;
   endtask

   task automatic m_nav(input int t);
      m_c[m_idx] = m_neg ? -m_val : m_val;
      m_idx = t;
      m_neg = m_c[t] < 0;
      m_val = m_neg ? -m_c[t] : m_c[t];
   endtask

   // mask bits: 0 digit, 1 del, 2 sign, 3 left, 4 right, 5 mode
   task automatic m_apply(input logic [5:0] m, input logic [3:0] d, output int lat);
      lat = 0;
      if (m[5]) begin
         if (m_gr) m_gr = 0;
         else begin m_c[m_idx] = m_neg ? -m_val : m_val; m_gr = 1; lat = ND; end
      end else if (m[3]) begin
         if (m_gr) m_pan = (m_pan + PSTEP) % 4096;
         else if (m_idx > 0) begin m_nav(m_idx - 1); lat = 2*ND; end
         else if (WRAP) begin m_nav(NC - 1); lat = 2*ND; end
      end else if (m[4]) begin
         if (m_gr) m_pan = (m_pan - PSTEP + 4096) % 4096;
         else if (m_idx < NC - 1) begin m_nav(m_idx + 1); lat = 2*ND; end
         else if (WRAP) begin m_nav(0); lat = 2*ND; end
      end else if (!m_gr) begin
         if (m[2]) m_neg = !m_neg;
         else if (m[1]) m_val = m_val / 10;
         else if (m[0] && d <= 9 && m_val < LIM) m_val = m_val * 10 + int'(d);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) bcnt = 0;
      else if (busy) bcnt++;
      else begin
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("digits", digits, bcd(e.val));
            chk("sign_neg", sign_neg, e.neg);
            chk("cur_idx", cur_idx, e.idx);
            chk("graph_mode", graph_mode, e.gr);
            chk("pan_x", pan_x, e.pan);
            chk("busy_cycles", bcnt, e.lat);
            for (int k = 0; k < NC; k++)
               chk($sformatf("coef%0d", k), $signed(coefs[CW*k +: CW]), $signed(e.c[CW*k +: CW]));
         end
         bcnt = 0;
      end
   end

   task automatic drive(input logic [5:0] m, input logic [3:0] d);
      {key_mode, key_right, key_left, key_sign, key_del, key_dig_v} = m;
      key_dig = d;
   endtask

   task automatic wait_q;
      int i = 0;
      while (q.size() > 0 && i < 200) begin @(posedge clk); i++; end
      chk("scoreboard_timeout", q.size(), 0);
      q.delete();
   endtask

   task automatic press(input logic [5:0] m, input logic [3:0] d, input bit junk);
      int lat;
      @(posedge clk); #1 drive(m, d);
      @(posedge clk); #1 drive(6'd0, 4'd0);
      m_apply(m, d, lat);
      q.push_back(snap(lat));
      if (junk && lat > 0) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1 drive(6'($urandom_range(1, 63)), 4'($urandom_range(0, 15)));
         @(posedge clk); #1 drive(6'd0, 4'd0);
      end
      wait_q();
   endtask

   initial begin
      logic [5:0] tm;
      int r;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      q.push_back(snap(0));
      wait_q();

      press(6'h01, 4'd1, 0); press(6'h01, 4'd2, 0); press(6'h01, 4'd3, 0); press(6'h04, 4'd0, 0);
      chk("pre_save_digits", digits, 20'h00123);
      chk("pre_save_neg", sign_neg, 1);
      press(6'h10, 4'd0, 0);
      chk("saved_coef0", $signed(coefs[31:0]), -123);
      chk("nav_idx1", cur_idx, 1);
      repeat (6) press(6'h01, 4'd9, 0);
      chk("full_digits", digits, 20'h99999);
      repeat (6) press(6'h02, 4'd0, 0);
      chk("empty_digits", digits, 0);
      press(6'h01, 4'd4, 0); press(6'h01, 4'd2, 0); press(6'h08, 4'd0, 0); press(6'h10, 4'd0, 0);
      chk("reload_digits", digits, 20'h00042);
      chk("coef0_kept", $signed(coefs[31:0]), -123);
      press(6'h20, 4'd0, 0);
      chk("graph_on", graph_mode, 1);
      repeat (2) press(6'h08, 4'd0, 0);
      chk("pan_420", pan_x, 420);
      repeat (3) press(6'h10, 4'd0, 0);
      press(6'h01, 4'd7, 0);
      chk("pan_390", pan_x, 390);
      press(6'h20, 4'd0, 0);
      press(6'h14, 4'd0, 1);
      chk("nav_over_sign_idx", cur_idx, 2);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         tm = r < 45 ? 6'h01 : r < 55 ? 6'h02 : r < 62 ? 6'h04 : r < 72 ? 6'h08 :
              r < 82 ? 6'h10 : r < 88 ? 6'h20 : 6'($urandom_range(1, 63));
         press(tm, 4'($urandom_range(0, 11)), $urandom_range(0, 3) == 0);
      end

      if (m_gr) press(6'h20, 4'd0, 0);
      tm = (m_idx < NC - 1) ? 6'h10 : 6'h08;
      @(posedge clk); #1 drive(tm, 4'd0);
      @(posedge clk); #1 drive(6'd0, 4'd0);
      repeat (2) @(posedge clk);
      #2 chk("busy_mid_save", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_digits", digits, 0);
      chk("rst_sign", sign_neg, 0);
      chk("rst_idx", cur_idx, 0);
      chk("rst_coefs", coefs == '0, 1);
      chk("rst_graph", graph_mode, 0);
      chk("rst_pan", pan_x, PINIT);
      chk("rst_busy", busy, 0);
      m_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      q.push_back(snap(0));
      wait_q();
      press(6'h08, 4'd0, 0);
      chk("boundary_left_idx", cur_idx, WRAP ? NC - 1 : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
